// File: rtl/time_update_datapath.sv
// ---------------------------------------------------------------------------
// time_update_datapath
//
// Register datapath behind the time-update PLA controller. Holds the current
// time as BCD seconds/minutes/hours. It executes the controller strobes to
// step one field at a time through a +1 second increment with ripple carry,
// and returns the carry-continue status bit u.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   tick                one-cycle 1 Hz pulse, latched into start
//   kc                  clear field index K, start, u and W
//   la / lb             load A with field[K] / B with limit[K]
//   ea                  A <= R
//   lr, s[1:0]          R <= {BCD(A+1), 00, A, A}[s]; update W and u
//   er                  field[K] <= R, K <= K+1 (ignored when K == 3)
//   set_en, set_hour,   direct time-set, sec forced to 00; overrides all
//   set_min             controller strobes in that cycle
//   sec, min, hour      current BCD time
//   start               tick pending, request to the controller
//   u                   carry-continue status (valid the cycle after lr)
//   day_tick            one-cycle pulse after the hours field wraps
//   overrun             sticky, tick arrived while start was still set
// ---------------------------------------------------------------------------
module time_update_datapath #(
    parameter logic [7:0] HOUR_MAX   = 8'h23,
    parameter logic [7:0] MINSEC_MAX = 8'h59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       kc,
    input  logic       la,
    input  logic       lb,
    input  logic       ea,
    input  logic       lr,
    input  logic       er,
    input  logic [1:0] s,
    input  logic       set_en,
    input  logic [7:0] set_hour,
    input  logic [7:0] set_min,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic [7:0] hour,
    output logic       start,
    output logic       u,
    output logic       day_tick,
    output logic       overrun
);

    // Field registers: 0 = sec, 1 = min, 2 = hour
    logic [7:0] field_reg [3];
    logic [7:0] set_val   [3];

    logic [1:0] k_reg;
    logic [7:0] a_reg;
    logic [7:0] b_reg;
    logic [7:0] r_reg;
    logic       w_reg;
    logic       start_reg;
    logic       u_reg;
    logic       overrun_reg;
    logic       day_tick_reg;

    logic [7:0] field_sel;
    logic [7:0] limit_sel;
    logic [7:0] r_src;
    logic       k_valid;
    logic       a_eq_b;

    // BCD increment of one byte. A nibble outside 0-9 yields 0; the carry
    // out of the high nibble is dropped (99 -> 00).
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [3:0] lo;
        logic [3:0] hi;
        logic       carry;
        begin
            carry = 1'b0;
            if (v[3:0] == 4'd9) begin
                lo    = 4'd0;
                carry = 1'b1;
            end else if (v[3:0] > 4'd9) begin
                lo = 4'd0;
            end else begin
                lo = v[3:0] + 4'd1;
            end
            if (v[7:4] > 4'd9) begin
                hi = 4'd0;
            end else if (carry) begin
                hi = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
            end else begin
                hi = v[7:4];
            end
            bcd_inc = {hi, lo};
        end
    endfunction

    assign set_val[0] = 8'h00;
    assign set_val[1] = set_min;
    assign set_val[2] = set_hour;

    assign k_valid = (k_reg != 2'd3);
    assign a_eq_b  = (a_reg == b_reg);

    // K = 3 is past the hours field: A reads as 00 and B as FF so a
    // stray compare can never report a wrap.
    always_comb begin
        field_sel = 8'h00;
        limit_sel = 8'hFF;
        case (k_reg)
            2'd0: begin field_sel = field_reg[0]; limit_sel = MINSEC_MAX; end
            2'd1: begin field_sel = field_reg[1]; limit_sel = MINSEC_MAX; end
            2'd2: begin field_sel = field_reg[2]; limit_sel = HOUR_MAX;   end
            default: begin field_sel = 8'h00; limit_sel = 8'hFF; end
        endcase
    end

    always_comb begin
        r_src = a_reg;
        case (s)
            2'd0:    r_src = bcd_inc(a_reg);
            2'd1:    r_src = 8'h00;
            default: r_src = a_reg;
        endcase
    end

    // One register per time field; each is written by er only when K
    // addresses it, and by the time-set with its own preset value.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_field
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    field_reg[gi] <= 8'h00;
                end else if (set_en) begin
                    field_reg[gi] <= set_val[gi];
                end else if (er && (k_reg == 2'(gi))) begin
                    field_reg[gi] <= r_reg;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_reg        <= 2'd0;
            a_reg        <= 8'h00;
            b_reg        <= 8'h00;
            r_reg        <= 8'h00;
            w_reg        <= 1'b0;
            start_reg    <= 1'b0;
            u_reg        <= 1'b0;
            overrun_reg  <= 1'b0;
            day_tick_reg <= 1'b0;
        end else begin
            day_tick_reg <= 1'b0;
            if (tick && start_reg) begin
                overrun_reg <= 1'b1;
            end
            if (set_en) begin
                k_reg     <= 2'd0;
                start_reg <= 1'b0;
                u_reg     <= 1'b0;
                w_reg     <= 1'b0;
            end else begin
                // All right-hand sides are pre-edge values, so ea with lr
                // takes the old R and er with lr writes the old R.
                if (ea) begin
                    a_reg <= r_reg;
                end
                if (la) begin
                    a_reg <= field_sel;
                end
                if (lb) begin
                    b_reg <= limit_sel;
                end
                if (lr) begin
                    r_reg <= r_src;
                    w_reg <= a_eq_b;
                    u_reg <= a_eq_b && (k_reg < 2'd2);
                end
                if (er && k_valid) begin
                    k_reg        <= k_reg + 2'd1;
                    day_tick_reg <= (k_reg == 2'd2) && w_reg;
                end
                if (kc) begin
                    k_reg     <= 2'd0;
                    start_reg <= 1'b0;
                    u_reg     <= 1'b0;
                    w_reg     <= 1'b0;
                end
                // A tick coinciding with kc must not be lost.
                if (tick) begin
                    start_reg <= 1'b1;
                end
            end
        end
    end

    assign sec      = field_reg[0];
    assign min      = field_reg[1];
    assign hour     = field_reg[2];
    assign start    = start_reg;
    assign u        = u_reg;
    assign day_tick = day_tick_reg;
    assign overrun  = overrun_reg;

endmodule

// File: doc/time_update_datapath.md
# time_update_datapath

Register datapath driven by the time-update PLA controller. It holds the current time as BCD seconds, minutes and hours. It executes the controller's strobes (`kc`, `la`, `lb`, `ea`, `lr`, `er`, `s`) to apply a one-second increment with ripple carry, field by field, and returns the `u` status bit that the controller branches on. It also latches the 1 Hz tick into a start request for the controller, accepts a direct time-set, and emits a day-rollover pulse for the downstream date/calendar stage.

## Interface
Parameters:
- `HOUR_MAX`, default 8'h23: BCD limit of the hours field.
- `MINSEC_MAX`, default 8'h59: BCD limit of the minutes and seconds fields.

Ports:
- `clk`  in  1: system clock; all state changes on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `tick`  in  1: one-cycle 1 Hz pulse.
- `kc`  in  1: clear field index K to 0 and clear start request.
- `la`  in  1: load A with field[K].
- `lb`  in  1: load B with limit[K].
- `ea`  in  1: enable A update (A <= R).
- `lr`  in  1: load R from the source selected by `s`; update flags.
- `er`  in  1: write R into field[K], then K <= K+1.
- `s`  in  2: R source. 0 = BCD(A+1), 1 = 8'h00, 2 and 3 = A.
- `set_en`  in  1: direct time-set strobe.
- `set_hour`, `set_min`  in  8 each: BCD values for the time-set.
- `sec`, `min`, `hour`  out  8 each: current BCD time.
- `start`  out  1: tick pending; request to the controller.
- `u`  out  1: carry-continue status to the controller.
- `day_tick`  out  1: one-cycle pulse on hours wrap.
- `overrun`  out  1: sticky; a tick arrived while `start` was already set.

## Operation
- Registers: fields F[0]=sec, F[1]=min, F[2]=hour; K (2 bit); A, B, R (8 bit each); W (wrap flag); start; u; overrun.
- limit[K]: MINSEC_MAX for K=0 and K=1; HOUR_MAX for K=2.
- K=3 is out of range:
  - `la` loads 8'h00.
  - `lb` loads 8'hFF.
  - `er` is ignored and does not increment K.
- All strobes are sampled in the same cycle and use pre-edge register values. When `lr` and `er` are asserted together, `er` writes the old R.
- BCD(A+1):
  - Low nibble 9 → 0 with carry into the high nibble.
  - Otherwise +1.
  - Non-BCD input nibbles (A–F) produce 0 in that nibble.
- On `lr`:
  - R <= source selected by `s`.
  - W <= (A == B).
  - u <= (A == B) && (K < 2).
- On `er` with K < 3:
  - F[K] <= R; K <= K+1.
  - If K == 2 and W == 1, `day_tick` pulses the next cycle.
- On `ea`: A <= R (old R when combined with `lr`).
- On `kc`: K <= 0; start <= 0; u <= 0; W <= 0.
- Start request:
  - `tick` sets `start`.
  - If `tick` arrives while start==1, `overrun` is set. `overrun` clears only on reset.
  - `tick` in the same cycle as `kc`: `start` ends at 1 (set wins).
- Time-set (`set_en`):
  - hour <= set_hour; min <= set_min; sec <= 0; K <= 0; start <= 0; u <= 0; W <= 0.
  - Overrides every controller strobe in that cycle.
  - Values are not range-checked.
- Reset: all fields, K, A, B, R, W, start, u, day_tick and overrun are 0.

## Timing
- Each strobe takes effect at the next rising edge; outputs are registered, not combinational.
- `u` is valid the cycle after `lr`; the controller samples it in its following state.
- Nominal increment sequence: kc, la, lb, lr(s=0), er. The next field repeats la, lb, lr, er while u=1.
  - Without carry: 5 cycles.
  - Full midnight rollover: 13 cycles.
- `day_tick` is high exactly one cycle, the cycle after the hours `er` with W=1.
- `rst_n` assertion mid-sequence clears everything immediately (asynchronous). The controller must restart from its idle state.

## Test plan
- Reset with all inputs toggling → all outputs 0; after release, sec/min/hour = 00:00:00, start=0, u=0.
- 12:34:56, tick, then kc, la, lb, lr(s=0), er → sec=8'h57, u=0 after lr, min/hour unchanged, K=1.
- 12:59:59, full carry chain (s=1 on fields that wrap, s=0 on the last field) → time 13:00:00, u=1 after the sec and min `lr`, u=0 after the hour `lr`.
- 23:59:59 rollover → 00:00:00, `day_tick` high for exactly one cycle after the hours `er`, u=0 after the hours `lr`.
- Two ticks without an intervening kc → start=1, overrun=1; `overrun` stays set after kc and clears only on `rst_n`.
- `set_en` with 8'h07/8'h45 during a sequence (same cycle as `er`) → time 07:45:00, `er` ignored, K=0, start=0; `rst_n` low mid-sequence clears R and K asynchronously.
